fifo_burst_scheduler: RTL and testbench

Round-robin drain scheduler that shares one downstream consumer among NUM_PORTS synchronous FIFOs. It watches each FIFO's empty flag and combinational front data, and issues pops to at most one FIFO per cycle. Popped data goes into a single registered output slot with a valid/ready handshake. A granted port keeps ownership for up to BURST consecutive pops, so related entries from one source (e.g. one warp's requests) stay contiguous before the pointer rotates.

---
 rtl/fifo_burst_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_fifo_burst_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler: round-robin drain scheduler sharing one registered
// valid/ready output slot among NUM_PORTS synchronous FIFOs. A granted port
// keeps ownership for up to BURST consecutive pops before the pointer rotates.
// Optional feature macro: FIFO_SCHED_URGENT_EN adds the src_urgent input, which
// gives non-empty urgent ports precedence in selection and cuts non-urgent
// bursts short.
module fifo_burst_scheduler #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST     = 4,
    localparam int unsigned PTR_W    = $clog2(NUM_PORTS),
    localparam int unsigned CNT_W    = $clog2(BURST + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        src_empty,
    input  logic [NUM_PORTS*DATA_W-1:0] src_data,
`ifdef FIFO_SCHED_URGENT_EN
    input  logic [NUM_PORTS-1:0]        src_urgent,
`endif
    output logic [NUM_PORTS-1:0]        src_pop,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [PTR_W-1:0]            out_port,
    output logic                        out_last,
    output logic                        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PTR_W-1:0]       rr_q;
    logic [PTR_W-1:0]       rr_d;
    logic [PTR_W-1:0]       owner_q;
    logic [PTR_W-1:0]       owner_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    logic                   slot_free;
    logic [NUM_PORTS-1:0]   cand;
    logic [PTR_W-1:0]       sel;
    logic                   sel_found;
    int unsigned            idx;
    logic                   preempt;
    logic                   pop_en;
    logic [PTR_W-1:0]       pop_idx;
    logic                   pop_last;
    logic                   valid_d;

    // Next round-robin position after port p, wrapping at NUM_PORTS-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_PORTS - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Ports eligible for a fresh grant; urgent non-empty ports shadow the rest.
    always_comb begin
        cand = ~src_empty;
`ifdef FIFO_SCHED_URGENT_EN
        if (|(src_urgent & ~src_empty)) begin
            cand = src_urgent & ~src_empty;
        end
`endif
    end

`ifdef FIFO_SCHED_URGENT_EN
    logic [NUM_PORTS-1:0] owner_oh;

    // A non-urgent owner yields after its current pop when another urgent port waits.
    always_comb begin
        owner_oh = NUM_PORTS'(1) << owner_q;
        preempt  = !src_urgent[owner_q] && (|(src_urgent & ~src_empty & ~owner_oh));
    end
`else
    assign preempt = 1'b0;
`endif

    // First eligible port searching rr_q, rr_q+1, ... modulo NUM_PORTS.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!sel_found && cand[PTR_W'(idx)]) begin
                sel_found = 1'b1;
                sel       = PTR_W'(idx);
            end
        end
    end

    // Grant FSM next state, pop decision and slot load control.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        pop_en    = 1'b0;
        pop_idx   = owner_q;
        pop_last  = 1'b0;
        src_pop   = '0;
        slot_free = !out_valid || out_ready;

        case (state_q)
            IDLE: begin
                if (sel_found && slot_free) begin
                    pop_en  = 1'b1;
                    pop_idx = sel;
                    owner_d = sel;
                    cnt_d   = CNT_W'(1);
                    if (BURST > 1) begin
                        state_d = OWN;
                    end else begin
                        pop_last = 1'b1;
                        rr_d     = ptr_inc(sel);
                    end
                end
            end
            OWN: begin
                if (src_empty[owner_q]) begin
                    // Owner ran dry: release without a pop (one bubble cycle).
                    state_d = IDLE;
                    rr_d    = ptr_inc(owner_q);
                end else if (slot_free) begin
                    pop_en = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_W'(BURST)) begin
                        pop_last = 1'b1;
                        state_d  = IDLE;
                        rr_d     = ptr_inc(owner_q);
                    end else if (preempt) begin
                        state_d = IDLE;
                        rr_d    = ptr_inc(owner_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = pop_en || (out_valid && !out_ready);

        // Pops are held off while reset is asserted so no FIFO entry is lost.
        if (pop_en && !rst) begin
            src_pop[pop_idx] = 1'b1;
        end
    end

    // Grant state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output slot: load on pop, drain on consume, busy tracks grant or held entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= valid_d;
            busy      <= (state_d == OWN) || valid_d;
            if (pop_en) begin
                out_data <= src_data[32'(pop_idx)*DATA_W +: DATA_W];
                out_port <= pop_idx;
                out_last <= pop_last;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Bench for fifo_burst_scheduler: directed per-cycle grant tables, hand-written
// stall / reset / urgent sequences, and randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_fifo_burst_scheduler;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int SEQ   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     src_empty;
    logic [NP*DW-1:0]  src_data;
`ifdef FIFO_SCHED_URGENT_EN
    logic [NP-1:0]     src_urgent;
`endif
    logic [NP-1:0]     src_pop;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_port;
    logic              out_last;
    logic              busy;

    fifo_burst_scheduler #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .BURST     (BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_empty  (src_empty),
        .src_data   (src_data),
`ifdef FIFO_SCHED_URGENT_EN
        .src_urgent (src_urgent),
`endif
        .src_pop    (src_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_port   (out_port),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Source FIFO contents; element 0 is the front entry.
    logic [DW-1:0] fq [NP][$];

    // Reference model: current grant holder (-1 = none), pointer, burst count, slot.
    int            m_owner;
    int            m_rr;
    int            m_cnt;
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_port;
    bit            m_last;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0]         fill;  // entry count per port, port 0 in the low nibble
        logic [SEQ-1:0][2:0] seq;   // port popped each cycle, 7 = no pop
        logic [SEQ-1:0]      last;  // out_last expected for that cycle's pop
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] fill, input string s, input string l);
        vec_t v;
        v.fill = fill;
        for (int i = 0; i < SEQ; i++) begin
            v.seq[i]  = (s[i] == "-") ? 3'd7 : 3'(s[i] - 8'h30);
            v.last[i] = (l[i] == "L");
        end
        return v;
    endfunction

    function automatic bit is_urg(input int p);
`ifdef FIFO_SCHED_URGENT_EN
        return src_urgent[p];
`else
        // No urgent input in this build; p is always a valid index.
        return (p < 0);
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_port  = 0;
        m_last  = 1'b0;
    endtask

    // Assert reset, check async clear, release with all FIFOs shown empty.
    task automatic do_reset(input bit clr);
        rst       = 1'b1;
        out_ready = 1'b0;
        if (clr) begin
            for (int p = 0; p < NP; p++) fq[p].delete();
            src_empty = '1;
        end
`ifdef FIFO_SCHED_URGENT_EN
        src_urgent = '0;
`endif
        model_reset();
        #1;
        chk("rst_src_pop",   64'(src_pop),   64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_port",  64'(out_port),  64'(0));
        chk("rst_out_last",  64'(out_last),  64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        @(negedge clk);
        src_empty = '1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: check slot vs model, drive FIFO view, check pop, advance model.
    task automatic step(input bit rdy, output logic [NP-1:0] pop_s);
        int            ep;
        int            pick;
        int            p;
        bit            el;
        bit            sf;
        bit            oth;
        logic [NP-1:0] exp_pop;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_port", 64'(out_port), 64'(m_port));
            chk("out_last", 64'(out_last), 64'(m_last));
        end
        chk("busy", 64'(busy), 64'(m_owner >= 0 || m_valid));
        for (int q = 0; q < NP; q++) begin
            src_empty[q] = (fq[q].size() == 0);
            if (fq[q].size() == 0) src_data[q*DW +: DW] = DW'($urandom);
            else                   src_data[q*DW +: DW] = fq[q][0];
        end
        out_ready = rdy;
        #1;
        ep = -1;
        el = 1'b0;
        sf = !m_valid || rdy;
        if (m_owner < 0) begin
            pick = -1;
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < NP; k++) begin
                    p = (m_rr + k) % NP;
                    if (pick < 0 && fq[p].size() > 0 && (pass == 1 || is_urg(p))) pick = p;
                end
            end
            if (pick >= 0 && sf) begin
                ep    = pick;
                m_cnt = 1;
                if (BURST > 1) m_owner = pick;
                else begin
                    el   = 1'b1;
                    m_rr = (pick + 1) % NP;
                end
            end
        end else if (fq[m_owner].size() == 0) begin
            m_rr    = (m_owner + 1) % NP;
            m_owner = -1;
        end else if (sf) begin
            oth = 1'b0;
            for (int k = 0; k < NP; k++) begin
                if (k != m_owner && is_urg(k) && fq[k].size() > 0) oth = 1'b1;
            end
            ep = m_owner;
            m_cnt++;
            if (m_cnt == BURST) begin
                el      = 1'b1;
                m_rr    = (m_owner + 1) % NP;
                m_owner = -1;
            end else if (oth && !is_urg(m_owner)) begin
                m_rr    = (m_owner + 1) % NP;
                m_owner = -1;
            end
        end
        exp_pop = (ep >= 0) ? (NP'(1) << ep) : '0;
        chk("src_pop", 64'(src_pop), 64'(exp_pop));
        chk("pop_legal", 64'(((src_pop & src_empty) == '0) && $onehot0(src_pop)), 64'(1));
        pop_s = src_pop;
        if (ep >= 0) begin
            m_valid = 1'b1;
            m_data  = fq[ep].pop_front();
            m_port  = ep;
            m_last  = el;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [NP-1:0] pop_s;
        logic [3:0]    want;

        src_data  = '0;
        src_empty = '1;
        out_ready = 1'b0;

        vecs[0] = mk(16'h0000, "----------------", "................");
        vecs[1] = mk(16'h0060, "111111----------", "...L............");
        vecs[2] = mk(16'h8888, "0000111122223333", "...L...L...L...L");
        vecs[3] = mk(16'h2001, "0-33------------", "................");
        vecs[4] = mk(16'h0520, "11-22222--------", "......L.........");

        // Directed grant tables with out_ready held high.
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b1);
            for (int p = 0; p < NP; p++) begin
                for (int j = 0; j < int'(vecs[v].fill[p*4 +: 4]); j++) begin
                    fq[p].push_back({8'(p), 8'(j), 16'($urandom)});
                end
            end
            for (int c = 0; c <= SEQ; c++) begin
                if (c > 0) begin
                    @(posedge clk);
                    #1;
                    if (vecs[v].seq[c-1] != 3'd7) begin
                        chk("vec_port", 64'(out_port), 64'(vecs[v].seq[c-1]));
                        chk("vec_last", 64'(out_last), 64'(vecs[v].last[c-1]));
                    end
                end
                if (c < SEQ) begin
                    step(1'b1, pop_s);
                    want = (vecs[v].seq[c] == 3'd7) ? 4'b0000 : (4'(1) << vecs[v].seq[c]);
                    chk("vec_pop", 64'(pop_s), 64'(want));
                end
            end
        end

        // Backpressure: one load, five stalled cycles, resume on out_ready.
        do_reset(1'b1);
        for (int j = 0; j < 3; j++) fq[2].push_back({8'd2, 8'(j), 16'h00A5});
        step(1'b1, pop_s);
        chk("bp_first_pop", 64'(pop_s), 64'(4'b0100));
        for (int k = 0; k < 5; k++) begin
            step(1'b0, pop_s);
            chk("bp_stall_pop", 64'(pop_s), 64'(0));
            chk("bp_stall_data", 64'(out_data), 64'(32'h020000A5));
        end
        step(1'b1, pop_s);
        chk("bp_resume_pop", 64'(pop_s), 64'(4'b0100));
        step(1'b1, pop_s);
        chk("bp_third_pop", 64'(pop_s), 64'(4'b0100));
        step(1'b1, pop_s);
        chk("bp_bubble", 64'(pop_s), 64'(0));

        // Reset mid-burst: grant and slot dropped, remaining entries re-granted fresh.
        do_reset(1'b1);
        for (int j = 0; j < 8; j++) fq[0].push_back(DW'($urandom));
        step(1'b1, pop_s);
        step(1'b1, pop_s);
        do_reset(1'b0);
        step(1'b1, pop_s);
        chk("rst_regrant", 64'(pop_s), 64'(4'b0001));
        for (int k = 0; k < 4; k++) step(1'b1, pop_s);

`ifdef FIFO_SCHED_URGENT_EN
        // Urgent port cuts a non-urgent burst after the current pop.
        do_reset(1'b1);
        for (int j = 0; j < 8; j++) fq[0].push_back(DW'($urandom));
        step(1'b1, pop_s);
        step(1'b1, pop_s);
        for (int j = 0; j < 2; j++) fq[2].push_back(DW'($urandom));
        src_urgent = 4'b0100;
        step(1'b1, pop_s);
        chk("urg_final_pop", 64'(pop_s), 64'(4'b0001));
        @(posedge clk);
        #1;
        chk("urg_last_clear", 64'(out_last), 64'(0));
        step(1'b1, pop_s);
        chk("urg_grant", 64'(pop_s), 64'(4'b0100));
        src_urgent = '0;
`endif

        // Randomized traffic, backpressure and occasional mid-run reset.
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (fq[p].size() < 6 && $urandom_range(0, 3) == 0) fq[p].push_back(DW'($urandom));
            end
`ifdef FIFO_SCHED_URGENT_EN
            src_urgent = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
`endif
            step($urandom_range(0, 3) != 0, pop_s);
            if (i % 997 == 500) do_reset(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
